alu_seq: RTL

- Operand-fetch and writeback sequencer directly upstream and downstream of the combinational 16-bit ALU in the Hmmm core.
- Accepts one register-register arithmetic command (op, rX, rY, rD).
- Reads rX and rY from the synchronous register file into the ALU operand registers tmp1/tmp2, pulses the ALU enable, then writes the result to rD and latches the zero/carry/sign flags.

---
 rtl/alu_seq.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Operand-fetch / writeback sequencer around the combinational Hmmm ALU.
// Optional feature: define ALU_SEQ_SAMEREG_EN to skip CAPY when rx == ry.
module alu_seq #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [2:0]        cmd_op_i,
  input  logic [REG_AW-1:0] cmd_rx_i,
  input  logic [REG_AW-1:0] cmd_ry_i,
  input  logic [REG_AW-1:0] cmd_rd_i,
  output logic [REG_AW-1:0] rf_raddr_o,
  input  logic [DATA_W-1:0] rf_rdata_i,
  output logic [DATA_W-1:0] tmp1_o,
  output logic [DATA_W-1:0] tmp2_o,
  output logic [2:0]        alu_op_o,
  output logic              alu_enable_o,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic              alu_zero_i,
  input  logic              alu_carry_i,
  input  logic              alu_sign_i,
  output logic              rf_we_o,
  output logic [REG_AW-1:0] rf_waddr_o,
  output logic [DATA_W-1:0] rf_wdata_o,
  output logic              flag_zero_o,
  output logic              flag_carry_o,
  output logic              flag_sign_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [2:0] {IDLE, RDX, RDY, CAPY, EXEC, WB} state_e;

  state_e              state_q, state_d;
  logic [2:0]          op_q;
  logic [REG_AW-1:0]   rx_q, ry_q, rd_q, raddr_q;
  logic [DATA_W-1:0]   tmp1_q, tmp2_q, res_q;
  logic [2:0]          smp_flags_q, flags_q;
  logic                fault_q, fault_d;
  logic [DATA_W-1:0]   opa_d, opb_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    cmd_ready_o  = 1'b0;
    alu_enable_o = 1'b0;
    done_o       = 1'b0;
    err_o        = 1'b0;
    rf_we_o      = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) state_d = RDX;
      end
      RDX: state_d = RDY;
      RDY: begin
`ifdef ALU_SEQ_SAMEREG_EN
        state_d = (rx_q == ry_q) ? EXEC : CAPY;
`else
        state_d = CAPY;
`endif
      end
      CAPY: state_d = EXEC;
      EXEC: begin
        alu_enable_o = 1'b1;
        state_d      = WB;
      end
      WB: begin
        done_o  = 1'b1;
        err_o   = fault_q;
        rf_we_o = !fault_q && (rd_q != '0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // r0 is hardwired to zero regardless of what the register file returns
  always_comb begin
    opa_d   = (rx_q == '0) ? '0 : rf_rdata_i;
    opb_d   = (ry_q == '0) ? '0 : rf_rdata_i;
    fault_d = (op_q >= 3'd5) || (((op_q == 3'd3) || (op_q == 3'd4)) && (tmp2_q == '0));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q        <= '0;
      rx_q        <= '0;
      ry_q        <= '0;
      rd_q        <= '0;
      raddr_q     <= '0;
      tmp1_q      <= '0;
      tmp2_q      <= '0;
      res_q       <= '0;
      smp_flags_q <= '0;
      flags_q     <= '0;
      fault_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            op_q    <= cmd_op_i;
            rx_q    <= cmd_rx_i;
            ry_q    <= cmd_ry_i;
            rd_q    <= cmd_rd_i;
            raddr_q <= cmd_rx_i;
          end
        end
        RDX: raddr_q <= ry_q;
        RDY: begin
          tmp1_q <= opa_d;
`ifdef ALU_SEQ_SAMEREG_EN
          if (rx_q == ry_q) tmp2_q <= opa_d;
`endif
        end
        CAPY: tmp2_q <= opb_d;
        EXEC: begin
          fault_q <= fault_d;
          if (!fault_d) begin
            res_q       <= alu_result_i;
            smp_flags_q <= {alu_zero_i, alu_carry_i, alu_sign_i};
          end
        end
        WB: begin
          if (!fault_q) flags_q <= smp_flags_q;
        end
        default: ;
      endcase
    end
  end

  assign rf_raddr_o   = raddr_q;
  assign tmp1_o       = tmp1_q;
  assign tmp2_o       = tmp2_q;
  assign alu_op_o     = op_q;
  assign rf_waddr_o   = rd_q;
  assign rf_wdata_o   = res_q;
  assign flag_zero_o  = flags_q[2];
  assign flag_carry_o = flags_q[1];
  assign flag_sign_o  = flags_q[0];

endmodule
